// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_pkg                                                    |
// | Brief   : Opcode map, sequencer state encoding and latency helpers   |
// |           shared by the ALU, the control unit and alu_sequencer.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package alu_pkg;

  // All 16 encodings are defined, so the sequencer never sees an unknown op.
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_MUL = 4'h2,
    ALU_SL  = 4'h3,
    ALU_DIV = 4'h4,
    ALU_MOD = 4'h5,
    ALU_NOT = 4'h6,
    ALU_OR  = 4'h7,
    ALU_AND = 4'h8,
    ALU_XOR = 4'h9,
    ALU_EQ  = 4'hA,
    ALU_NEQ = 4'hB,
    ALU_LT  = 4'hC,
    ALU_LE  = 4'hD,
    ALU_GT  = 4'hE,
    ALU_GE  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  // Number of cycles the ALU inputs must be held stable for a given op.
  function automatic int unsigned op_latency(input alu_op_e op,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat);
    int unsigned lat;
    case (op)
      ALU_MUL:          lat = mul_lat;
      ALU_DIV, ALU_MOD: lat = div_lat;
      default:          lat = 1;
    endcase
    return lat;
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

  // Compares whose single-bit answer comes back from the ALU in bit 0.
  function automatic logic is_alu_cmp_op(input alu_op_e op);
    return (op == ALU_EQ) || (op == ALU_LT) || (op == ALU_LE) ||
           (op == ALU_GT) || (op == ALU_GE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_sequencer                                              |
// | Brief   : Request/response front end for the shared multicycle ALU.  |
// |           Registers one request, holds the ALU inputs for the op     |
// |           latency, screens div-by-zero / oversized shifts / compare  |
// |           masking, and returns the result over a valid/ready port.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned DIV_LAT   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [WORD_SIZE-1:0] req_a,
  input  logic [WORD_SIZE-1:0] req_b,
  input  logic [TAG_W-1:0]     req_tag,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [3:0]           alu_op,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_result,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_div_zero,
  output logic                 busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  // Counter only has to reach MAX_LAT-1.
  localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [WORD_SIZE-1:0] SHIFT_LIMIT = WORD_SIZE'(WORD_SIZE);

  // State and datapath registers
  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  alu_op_e                op_q, op_d;
  logic [WORD_SIZE-1:0]   a_q, a_d;
  logic [WORD_SIZE-1:0]   b_q, b_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [WORD_SIZE-1:0]   res_q, res_d;
  logic [TAG_W-1:0]       rtag_q, rtag_d;
  logic                   dz_q, dz_d;

  // Combinational helpers
  alu_op_e                w_req_op;
  logic [CNT_W-1:0]       w_accept_cnt;
  logic                   w_b_zero;
  logic [WORD_SIZE-1:0]   w_cap_result;
  logic                   w_cap_div_zero;

  assign w_req_op = alu_op_e'(req_op);
  assign w_b_zero = (b_q == '0);

  // Divide by zero never reaches the ALU, so it does not wait the divide latency.
  function automatic int unsigned accept_latency(input alu_op_e op,
                                                 input logic b_is_zero);
    int unsigned lat;
    lat = op_latency(op, MUL_LAT, DIV_LAT);
    if (is_div_op(op) && b_is_zero) begin
      lat = 1;
    end
    return lat;
  endfunction

  // Initial countdown for a request accepted this cycle (lat-1).
  always_comb begin
    w_accept_cnt = CNT_W'(accept_latency(w_req_op, (req_b == '0)) - 1);
  end

  // Result screening applied at capture time, from the held operands and ALU output.
  always_comb begin
    w_cap_result   = alu_out;
    w_cap_div_zero = 1'b0;
    case (op_q)
      ALU_SL: begin
        if (b_q >= SHIFT_LIMIT) begin
          w_cap_result = '0;
        end
      end
      ALU_DIV: begin
        if (w_b_zero) begin
          w_cap_result   = '1;
          w_cap_div_zero = 1'b1;
        end
      end
      ALU_MOD: begin
        if (w_b_zero) begin
          w_cap_result   = a_q;
          w_cap_div_zero = 1'b1;
        end
      end
      ALU_NEQ: begin
        // Computed locally; the ALU's answer for NEQ is not trusted.
        w_cap_result = {{(WORD_SIZE-1){1'b0}}, (a_q != b_q)};
      end
      default: begin
        if (is_alu_cmp_op(op_q)) begin
          w_cap_result = {{(WORD_SIZE-1){1'b0}}, alu_out[0]};
        end
      end
    endcase
  end

  // Next-state, datapath loads and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    res_d     = res_q;
    rtag_d    = rtag_q;
    dz_d      = dz_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          op_d    = w_req_op;
          a_d     = req_a;
          b_d     = req_b;
          tag_d   = req_tag;
          cnt_d   = w_accept_cnt;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_d   = w_cap_result;
          rtag_d  = tag_q;
          dz_d    = w_cap_div_zero;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      rtag_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      rtag_q  <= rtag_d;
      dz_q    <= dz_d;
    end
  end

  // ALU inputs come straight from the held registers; NOT takes only operand A.
  assign alu_a        = a_q;
  assign alu_b        = (op_q == ALU_NOT) ? '0 : b_q;
  assign alu_op       = op_q;
  assign rsp_result   = res_q;
  assign rsp_tag      = rtag_q;
  assign rsp_div_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu_sequencer                                           |
// | Brief   : Scoreboard bench for alu_sequencer with a behavioural ALU  |
// |           beside the DUT and a reference result model.               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_tag;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [63:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_div_zero;
  logic        busy;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  tag;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          bp_mode  = 0;
  logic [63:0] cur_a, cur_b;
  logic [3:0]  cur_op;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer #(.WORD_SIZE(64), .TAG_W(4), .MUL_LAT(3), .DIV_LAT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_div_zero(rsp_div_zero), .busy(busy)
  );

  // Unscreened ALU: junk for div-by-zero, wrapped shifts, inverted NEQ and
  // unmasked upper bits on compares, so the sequencer's screening matters.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      4'h0: alu_out = alu_a + alu_b;
      4'h1: alu_out = alu_a - alu_b;
      4'h2: alu_out = alu_a * alu_b;
      4'h3: alu_out = alu_a << alu_b[5:0];
      4'h4: alu_out = (alu_b == 0) ? 64'h0BAD_0BAD_0BAD_0BAD : alu_a / alu_b;
      4'h5: alu_out = (alu_b == 0) ? 64'h0BAD_0BAD_0BAD_0BAD : alu_a % alu_b;
      4'h6: alu_out = ~alu_a;
      4'h7: alu_out = alu_a | alu_b;
      4'h8: alu_out = alu_a & alu_b;
      4'h9: alu_out = alu_a ^ alu_b;
      4'hA: alu_out = {alu_a[63:1], alu_a == alu_b};
      4'hB: alu_out = {alu_b[63:1], alu_a == alu_b};
      4'hC: alu_out = {alu_b[63:1], alu_a <  alu_b};
      4'hD: alu_out = {alu_a[63:1], alu_a <= alu_b};
      4'hE: alu_out = {alu_b[63:1], alu_a >  alu_b};
      4'hF: alu_out = {alu_a[63:1], alu_a >= alu_b};
      default: alu_out = '0;
    endcase
  end

  // Reference result straight from the operation definitions.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a * b;
      4'h3: return (b >= 64) ? 64'd0 : (a << b);
      4'h4: return (b == 0) ? {64{1'b1}} : a / b;
      4'h5: return (b == 0) ? a : a % b;
      4'h6: return ~a;
      4'h7: return a | b;
      4'h8: return a & b;
      4'h9: return a ^ b;
      4'hA: return (a == b) ? 64'd1 : 64'd0;
      4'hB: return (a != b) ? 64'd1 : 64'd0;
      4'hC: return (a <  b) ? 64'd1 : 64'd0;
      4'hD: return (a <= b) ? 64'd1 : 64'd0;
      4'hE: return (a >  b) ? 64'd1 : 64'd0;
      default: return (a >= b) ? 64'd1 : 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] b);
    if (op == 4'h2) return 3;
    if ((op == 4'h4 || op == 4'h5) && b != 0) return 8;
    return 1;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Present a request; while the DUT is busy the fields carry junk with valid high.
  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
    int guard;
    guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    while (!req_ready && guard < 100) begin
      req_op = 4'($urandom()); req_a = rnd64(); req_b = rnd64(); req_tag = 4'($urandom());
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("accept_timeout", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b0;
      return;
    end
    req_op = op; req_a = a; req_b = b; req_tag = tag;
    cur_a  = a;
    cur_b  = (op == 4'h6) ? 64'd0 : b;
    cur_op = op;
    sb.push_back('{res: ref_result(op, a, b), tag: tag, dz: ((op == 4'h4 || op == 4'h5) && b == 0),
                   lat: ref_lat(op, b), acc: cyc});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 4'($urandom()); req_a = rnd64(); req_b = rnd64();
  endtask

  // ALU inputs must equal the accepted operands on every EXEC cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && busy && !rsp_valid) begin
        check("exec_alu_a", alu_a, cur_a);
        check("exec_alu_b", alu_b, cur_b);
        check("exec_alu_op", {60'd0, alu_op}, {60'd0, cur_op});
      end
    end
  end

  // Response monitor: pops the scoreboard on each new response and drives rsp_ready.
  initial begin
    exp_t e;
    bit   in_rsp, hs_pending, have_exp;
    int   hold;
    in_rsp = 0; hs_pending = 0; have_exp = 0; hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_rsp = 0; hs_pending = 0; hold = 0;
        continue;
      end
      if (hs_pending) begin
        check("req_ready_after_hs", {63'd0, req_ready}, 64'd1);
        check("rsp_valid_after_hs", {63'd0, rsp_valid}, 64'd0);
        hs_pending = 0;
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1;
          if (sb.size() == 0) begin
            check("stale_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            have_exp = 0;
            hold = 0;
          end else begin
            e = sb.pop_front();
            have_exp = 1;
            check("latency", 64'(cyc - e.acc), 64'(e.lat + 1));
            hold = (bp_mode == 2) ? 5 : (bp_mode == 1) ? $urandom_range(0, 3) : 0;
          end
        end
        if (have_exp) begin
          check("rsp_result", rsp_result, e.res);
          check("rsp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
          check("rsp_div_zero", {63'd0, rsp_div_zero}, {63'd0, e.dz});
          check("req_ready_in_resp", {63'd0, req_ready}, 64'd0);
        end
        if (hold > 0) begin
          rsp_ready = 1'b0;
          hold--;
        end else begin
          rsp_ready = 1'b1;
        end
        if (rsp_ready) begin
          hs_pending = 1;
          in_rsp = 0;
        end
      end else begin
        in_rsp = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Reset values expected from the DUT right after a reset edge.
  task automatic check_reset_state(input string tagname);
    check({tagname, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    check({tagname, "_busy"}, {63'd0, busy}, 64'd0);
    check({tagname, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
    check({tagname, "_alu_op"}, {60'd0, alu_op}, 64'd0);
    check({tagname, "_alu_a"}, alu_a, 64'd0);
    check({tagname, "_alu_b"}, alu_b, 64'd0);
    check({tagname, "_rsp_result"}, rsp_result, 64'd0);
    check({tagname, "_rsp_tag"}, {60'd0, rsp_tag}, 64'd0);
    check({tagname, "_rsp_div_zero"}, {63'd0, rsp_div_zero}, 64'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [63:0] a, b;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    cur_a = '0; cur_b = '0; cur_op = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Directed cases
    bp_mode = 0;
    send(4'h0, 64'd5, 64'd7, 4'd3);
    send(4'h2, 64'h1_0000_0000, 64'h1_0000_0000, 4'd1);
    send(4'h4, 64'd100, 64'd0, 4'd2);
    send(4'h5, 64'd100, 64'd7, 4'd4);
    send(4'hB, 64'd9, 64'd9, 4'd5);
    send(4'hB, 64'd9, 64'd8, 4'd6);
    send(4'h3, 64'd1, 64'd64, 4'd7);
    send(4'h3, 64'd1, 64'd63, 4'd8);
    send(4'h5, 64'd100, 64'd0, 4'd12);
    send(4'h6, 64'h00FF_00FF_1234_5678, 64'hFFFF, 4'd13);

    // Backpressure with a second request waiting
    bp_mode = 2;
    send(4'h9, 64'hA5A5_A5A5_0000_FFFF, 64'hFFFF_0000_5A5A_5A5A, 4'd9);
    send(4'h1, 64'd3, 64'd10, 4'd10);
    send(4'hC, 64'd3, 64'd10, 4'd14);

    // Reset during the fifth EXEC cycle of a divide
    bp_mode = 0;
    send(4'h4, 64'd1000, 64'd3, 4'd11);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_state("midop_reset");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);

    // Randomized traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = rnd64();
      b  = rnd64();
      if ($urandom_range(0, 3) == 0) begin
        a = 64'($urandom_range(0, 300));
        b = 64'($urandom_range(0, 20));
      end
      if (op == 4'h3) b = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 80)) : b;
      if ((op == 4'h4 || op == 4'h5) && $urandom_range(0, 3) == 0) b = 64'd0;
      if (op >= 4'hA && $urandom_range(0, 2) == 0) b = a;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(op, a, b, 4'($urandom()));
    end

    // Drain outstanding responses
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multicycle-datapath front end that drives the shared combinational ALU.
- Accepts one operation request from the decode/control stage over a valid/ready handshake. It registers the operands and holds the ALU inputs stable for the per-op latency, then captures the ALU result.
- Presents the captured result, tag and flags to writeback over a second valid/ready handshake.
- Screens cases the ALU must not see: divide/mod by zero, oversized shifts, and compare results that need masking.

Parameters:
- WORD_SIZE, 64, operand and result width.
- TAG_W, 4, width of the request tag returned with the response.
- MUL_LAT, 3, cycles ALU inputs are held for ALU_MUL.
- DIV_LAT, 8, cycles ALU inputs are held for ALU_DIV and ALU_MOD.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  4  ALU opcode
- req_a  in  WORD_SIZE  operand A
- req_b  in  WORD_SIZE  operand B
- req_tag  in  TAG_W  caller tag
- alu_a  out  WORD_SIZE  to ALU A
- alu_b  out  WORD_SIZE  to ALU B
- alu_op  out  4  to ALU op
- alu_out  in  WORD_SIZE  from ALU out
- rsp_valid  out  1  result present
- rsp_ready  in  1  writeback accepts the result
- rsp_result  out  WORD_SIZE  captured result
- rsp_tag  out  TAG_W  tag of the completed request
- rsp_div_zero  out  1  DIV/MOD had B==0
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset values:
  - All outputs 0, except req_ready=1.
  - alu_op = ALU_ADD (4'h0).
  - State = IDLE, counter = 0.
- Reset mid-operation: abandons the operation; rsp_valid drops the next cycle; no response is produced.
- States: IDLE, EXEC, RESP.
  - IDLE: req_ready=1. On req_valid & req_ready:
    - register op, A, B and tag;
    - drive alu_* from the registered values;
    - load cnt = lat-1, where lat = MUL_LAT for MUL, DIV_LAT for DIV/MOD, otherwise 1;
    - go to EXEC.
  - EXEC: req_ready=0; alu_a, alu_b and alu_op are held constant.
    - While cnt != 0: decrement cnt.
    - When cnt == 0: capture the result per the rules below into rsp_result, set rsp_valid=1, go to RESP.
  - RESP: rsp_valid=1; rsp_result, rsp_tag and rsp_div_zero are held stable.
    - On rsp_ready: rsp_valid=0, go to IDLE.
    - req_ready stays 0 until IDLE is re-entered, so there is no back-to-back overlap.
- Latency: rsp_valid rises lat+1 cycles after the accepting edge. Minimum accept-to-accept spacing is lat+2 cycles, including the 1-cycle RESP handshake.
- Result rules at capture:
  - ALU_ADD, SUB, MUL, OR, AND, XOR: alu_out, wrap-around modulo 2^WORD_SIZE.
  - ALU_NOT: alu_b is driven 0; result alu_out.
  - ALU_SL:
    - if B >= WORD_SIZE: result 0, ALU bypassed;
    - else: alu_out.
  - ALU_DIV / ALU_MOD:
    - if B == 0: ALU bypassed, lat forced to 1, rsp_div_zero=1, result all-ones (DIV) or A (MOD);
    - else: alu_out, rsp_div_zero=0.
  - Compares (EQ, NEQ, LT, LE, GT, GE):
    - result = {WORD_SIZE-1 zeros, bit}, all unsigned;
    - NEQ bit = ~(A==B), computed locally. The sequencer does not rely on the ALU for NEQ; all other compares use alu_out[0].
- rsp_div_zero is 0 for every non-DIV/MOD op.
- Inputs while busy: req_valid held high during busy is ignored. Request fields need only be stable on the accepting edge.
- Unknown opcode: none exists, since all 16 codes are defined.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode constants: ADD=0, SUB=1, MUL=2, SL=3, DIV=4, MOD=5, NOT=6, OR=7, AND=8, XOR=9, EQ=10, NEQ=11, LT=12, LE=13, GT=14, GE=15;
  - the state encoding;
  - an op_latency function (op, MUL_LAT, DIV_LAT).
- Package constants are shared with the ALU and the control unit.
- No sub-module. The ALU is instantiated beside the sequencer, not inside it.

Test Plan:
1. ADD, A=5, B=7, tag=3, rsp_ready=1 -> rsp_valid 2 cycles after accept; result=12; tag=3; div_zero=0; req_ready back high the cycle after the handshake.
2. MUL, A=2^32, B=2^32 -> rsp_valid at 4 cycles; result=0 (wrap); alu_a/alu_b/alu_op constant over all 3 EXEC cycles.
3. DIV, A=100, B=0 -> rsp_valid at 2 cycles; result=64'hFFFF_FFFF_FFFF_FFFF; div_zero=1. Then MOD, A=100, B=7 -> rsp_valid at 9 cycles; result=2; div_zero=0.
4. NEQ, A=B=9 -> result=0. NEQ, A=9, B=8 -> result=1. SL, A=1, B=64 -> result=0. SL, A=1, B=63 -> result=64'h8000_0000_0000_0000.
5. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid; req_valid held high with a new request -> result and tag stable, req_ready=0 throughout; second request accepted only after the RESP handshake.
6. rst_n=0 during the 5th DIV EXEC cycle -> next cycle: IDLE, busy=0, req_ready=1, rsp_valid=0, alu_op=0; no stale response ever appears.
